// File: rtl/cmd_pkg.sv
// Shared types and opcode constants for the SPI command front-end.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    LEN,
    PAYLOAD,
    CHK,
    DISPATCH,
    DISCARD
  } state_t;

  localparam logic [7:0] CMD_NOP       = 8'd0;
  localparam logic [7:0] CMD_ENQUEUE   = 8'd1;
  localparam logic [7:0] CMD_SPRITE_WR = 8'd2;
  localparam logic [7:0] CMD_CLEAR     = 8'd3;

  localparam int DEF_PAYLOAD_BYTES = 6;

endpackage

// File: rtl/spi_cmd_dispatch_payload_packer.sv
// Payload byte-lane register with write counter.
module payload_packer #(
  parameter int BYTES = 6,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [CW-1:0]    idx,
  input  logic [7:0]       din,
  output logic [BYTES*8-1:0] data,
  output logic [CW-1:0]    cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (wr) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < BYTES; i++) begin
        if (idx == CW'(i))
          data[i*8 +: 8] <= din;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// SPI command frame decoder/dispatcher: opcode, length, payload -> channel.
// Optional trailing XOR checksum byte when CMD_CHECKSUM_EN is defined.
module spi_cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int NUM_CMDS      = 4,
  parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int CNT_W         = 8
) (
  input  logic                                 sys_clock,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 frame_end,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_data,
  output logic [NUM_CMDS-1:0]                  out_valid,
  input  logic [NUM_CMDS-1:0]                  out_ready,
  output logic [PAYLOAD_BYTES*8-1:0]           out_data,
  output logic [$clog2(PAYLOAD_BYTES+1)-1:0]   out_len,
  output logic [7:0]                           last_cmd,
  output logic                                 err_unknown,
  output logic                                 err_short,
`ifdef CMD_CHECKSUM_EN
  output logic                                 err_csum,
`endif
  output logic [CNT_W-1:0]                     drop_count,
  output logic                                 busy
);

  localparam int LEN_W = $clog2(PAYLOAD_BYTES+1);
  localparam int OPC_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam logic [7:0] NCMD8 = 8'(NUM_CMDS);
  localparam logic [7:0] PMAX8 = 8'(PAYLOAD_BYTES);
`ifdef CMD_CHECKSUM_EN
  localparam state_t DATA_DONE = CHK;
`else
  localparam state_t DATA_DONE = DISPATCH;
`endif

  state_t             state, nstate;
  logic [OPC_W-1:0]   opc_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   pk_cnt;
  logic               lat_opc, lat_len, pk_wr, pk_clr;
  logic               set_unk, set_short, drop_inc;
`ifdef CMD_CHECKSUM_EN
  logic               set_csum;
  logic [7:0]         csum_q;
`endif

  payload_packer #(
    .BYTES (PAYLOAD_BYTES),
    .CW    (LEN_W)
  ) u_packer (
    .clk  (sys_clock),
    .rst  (rst),
    .clr  (pk_clr),
    .wr   (pk_wr),
    .idx  (pk_cnt),
    .din  (byte_data),
    .data (out_data),
    .cnt  (pk_cnt)
  );

  always_comb begin
    nstate    = state;
    lat_opc   = 1'b0;
    lat_len   = 1'b0;
    pk_wr     = 1'b0;
    pk_clr    = 1'b0;
    set_unk   = 1'b0;
    set_short = 1'b0;
    drop_inc  = 1'b0;
`ifdef CMD_CHECKSUM_EN
    set_csum  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          nstate = OPC;
          pk_clr = 1'b1;
        end
      end
      OPC: begin
        if (byte_valid) begin
          lat_opc = 1'b1;
          if (byte_data < NCMD8) begin
            nstate = LEN;
          end else begin
            set_unk  = 1'b1;
            drop_inc = 1'b1;
            nstate   = DISCARD;
          end
        end
      end
      LEN: begin
        if (byte_valid) begin
          if (byte_data > PMAX8) begin
            set_unk  = 1'b1;
            drop_inc = 1'b1;
            nstate   = DISCARD;
          end else begin
            lat_len = 1'b1;
            nstate  = (byte_data == 8'd0) ? DATA_DONE : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          pk_wr = 1'b1;
          if (pk_cnt == len_q - LEN_W'(1))
            nstate = DATA_DONE;
        end
      end
`ifdef CMD_CHECKSUM_EN
      CHK: begin
        if (byte_valid) begin
          if (byte_data == csum_q) begin
            nstate = DISPATCH;
          end else begin
            set_csum = 1'b1;
            drop_inc = 1'b1;
            nstate   = IDLE;
          end
        end
      end
`endif
      DISPATCH: begin
        if (byte_valid)
          drop_inc = 1'b1;
        if (out_ready[opc_q])
          nstate = IDLE;
      end
      DISCARD: ;
      default: nstate = IDLE;
    endcase

    // frame_end judged against the state after this cycle's byte
    if (frame_end && state != IDLE) begin
      if (nstate inside {OPC, LEN, PAYLOAD, CHK}) begin
        set_short = 1'b1;
        drop_inc  = 1'b1;
        nstate    = IDLE;
      end else if (nstate == DISCARD) begin
        nstate = IDLE;
      end
    end

    if (frame_start && state != IDLE && state != DISPATCH) begin
      nstate    = OPC;
      pk_clr    = 1'b1;
      pk_wr     = 1'b0;
      lat_opc   = 1'b0;
      lat_len   = 1'b0;
      set_unk   = 1'b0;
      set_short = 1'b1;
      drop_inc  = 1'b1;
`ifdef CMD_CHECKSUM_EN
      set_csum  = 1'b0;
`endif
    end
  end

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      state       <= IDLE;
      opc_q       <= '0;
      len_q       <= '0;
      last_cmd    <= '0;
      err_unknown <= 1'b0;
      err_short   <= 1'b0;
      drop_count  <= '0;
    end else begin
      state <= nstate;
      if (lat_opc) begin
        last_cmd <= byte_data;
        opc_q    <= byte_data[OPC_W-1:0];
      end
      if (lat_len)
        len_q <= byte_data[LEN_W-1:0];
      if (set_unk)
        err_unknown <= 1'b1;
      if (set_short)
        err_short <= 1'b1;
      if (drop_inc && drop_count != '1)
        drop_count <= drop_count + CNT_W'(1);
    end
  end

`ifdef CMD_CHECKSUM_EN
  always_ff @(posedge sys_clock) begin
    if (rst) begin
      csum_q   <= '0;
      err_csum <= 1'b0;
    end else begin
      if (pk_clr)
        csum_q <= '0;
      else if (lat_opc || lat_len || pk_wr)
        csum_q <= csum_q ^ byte_data;
      if (set_csum)
        err_csum <= 1'b1;
    end
  end
`endif

  assign out_valid = (state == DISPATCH) ? (NUM_CMDS'(1) << opc_q) : '0;
  assign out_len   = len_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Self-checking bench for spi_cmd_dispatch: directed and random frames.
module tb_spi_cmd_dispatch;

  localparam int NC = 4;
  localparam int PB = 6;
  localparam int CW = 8;

  logic          sys_clock = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ready = '0;
  logic [PB*8-1:0] out_data;
  logic [2:0]    out_len;
  logic [7:0]    last_cmd;
  logic          err_unknown, err_short, busy;
  logic [CW-1:0] drop_count;
`ifdef CMD_CHECKSUM_EN
  logic          err_csum;
  int            e_csum = 0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int e_drop = 0;
  int e_unk  = 0;
  int e_short = 0;
  int e_last = 0;

  spi_cmd_dispatch dut (
    .sys_clock   (sys_clock),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_len     (out_len),
    .last_cmd    (last_cmd),
    .err_unknown (err_unknown),
    .err_short   (err_short),
`ifdef CMD_CHECKSUM_EN
    .err_csum    (err_csum),
`endif
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic drop1();
    e_drop = (e_drop < 255) ? e_drop + 1 : 255;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic status(input string tag);
    chk({tag, ".unk"},   64'(err_unknown), 64'(e_unk));
    chk({tag, ".short"}, 64'(err_short),   64'(e_short));
    chk({tag, ".drop"},  64'(drop_count),  64'(e_drop));
    chk({tag, ".last"},  64'(last_cmd),    64'(e_last));
    chk({tag, ".busy"},  64'(busy),        64'd0);
    chk({tag, ".ov"},    64'(out_valid),   64'd0);
`ifdef CMD_CHECKSUM_EN
    chk({tag, ".csum"},  64'(err_csum),    64'(e_csum));
`endif
  endtask

  // One frame; outcome predicted from opcode/length/bytes-sent rules.
  task automatic frame(input string tag, input int opc, input int len,
                       input int nsent, input int delay, input int extra);
    logic [47:0] ed;
    logic [7:0]  p;
    logic [7:0]  cs;
    fstart();
    send(8'(opc));
    e_last = opc;
    cs = 8'(opc);
    send(8'(len));
    cs ^= 8'(len);
    if (opc >= NC || len > PB) begin
      for (int i = 0; i < 2; i++) send(8'($urandom));
      fend();
      e_unk = 1;
      drop1();
    end else if (nsent < len) begin
      for (int i = 0; i < nsent; i++) send(8'($urandom));
      fend();
      e_short = 1;
      drop1();
    end else begin
      ed = '0;
      for (int i = 0; i < len; i++) begin
        p = 8'($urandom);
        ed[i*8 +: 8] = p;
        cs ^= p;
        send(p);
      end
`ifdef CMD_CHECKSUM_EN
      send(cs);
`endif
      chk({tag, ".ov"},  64'(out_valid), 64'(1) << opc);
      chk({tag, ".dat"}, 64'(out_data),  64'(ed));
      chk({tag, ".len"}, 64'(out_len),   64'(len));
      for (int c = 0; c < delay; c++) begin
        if (c < extra) begin
          byte_valid = 1'b1;
          byte_data  = 8'($urandom);
          drop1();
        end
        tick();
        byte_valid = 1'b0;
        chk({tag, ".hold"}, 64'(out_valid), 64'(1) << opc);
        chk({tag, ".hdat"}, 64'(out_data),  64'(ed));
      end
      out_ready = NC'(1) << opc;
      tick();
      out_ready = '0;
      fend();
    end
    status(tag);
  endtask

  task automatic clear_model();
    e_drop = 0; e_unk = 0; e_short = 0; e_last = 0;
`ifdef CMD_CHECKSUM_EN
    e_csum = 0;
`endif
  endtask

  initial begin
    int o, l, n;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.data", 64'(out_data), 64'd0);
    chk("rst.len",  64'(out_len),  64'd0);
    status("rst");

    send(8'h55);
    status("idle_byte");

    // normal frame, then back-pressure with two dropped bytes
    frame("norm", 1, 6, 6, 0, 0);
    frame("bp", 1, 6, 6, 5, 2);
    frame("after_bp", 2, 3, 3, 1, 0);

    frame("unk_opc", 7, 2, 0, 0, 0);
    frame("after_unk", 0, 4, 4, 0, 0);
    frame("unk_len", 2, 7, 0, 0, 0);
    frame("short", 2, 4, 2, 0, 0);
    frame("zero", 3, 0, 0, 2, 1);

    // frame_end with the final byte still dispatches
    fstart(); send(8'd2); send(8'd2); send(8'h11);
    byte_valid = 1'b1; byte_data = 8'h22; frame_end = 1'b1;
    tick();
    byte_valid = 1'b0; frame_end = 1'b0;
`ifdef CMD_CHECKSUM_EN
    send(8'd2 ^ 8'd2 ^ 8'h11 ^ 8'h22);
`endif
    e_last = 2;
    chk("end_last.ov",  64'(out_valid), 64'h4);
    chk("end_last.dat", 64'(out_data),  64'h2211);
    out_ready = 4'h4; tick(); out_ready = '0;
    status("end_last");

    // restart in the middle of a frame
    fstart(); send(8'd1); send(8'd4); send(8'h99);
    fstart();
    e_short = 1; drop1();
    send(8'd3); send(8'd0);
`ifdef CMD_CHECKSUM_EN
    send(8'd3);
`endif
    e_last = 3;
    chk("restart.ov",  64'(out_valid), 64'h8);
    chk("restart.dat", 64'(out_data),  64'd0);
    out_ready = 4'h8; tick(); out_ready = '0;
    status("restart");

    // reset in the middle of the payload
    fstart(); send(8'd1); send(8'd6);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    rst = 1'b1; tick(); rst = 1'b0;
    clear_model();
    chk("mid_rst.data", 64'(out_data), 64'd0);
    chk("mid_rst.len",  64'(out_len),  64'd0);
    status("mid_rst");
    frame("post_rst", 1, 6, 6, 0, 0);

`ifdef CMD_CHECKSUM_EN
    fstart(); send(8'd1); send(8'd1); send(8'h5A);
    send(8'd1 ^ 8'd1 ^ 8'h5A ^ 8'hFF);
    e_last = 1; e_csum = 1; drop1();
    fend();
    status("bad_csum");
`endif

    for (int k = 0; k < 24; k++) begin
      o = $urandom_range(0, 5);
      l = $urandom_range(0, 8);
      n = ($urandom_range(0, 3) == 0 && l > 0) ? $urandom_range(0, l - 1) : l;
      frame("rand", o, l, n, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // saturate the drop counter with bytes during back-pressure
    fstart(); send(8'd0); send(8'd0);
`ifdef CMD_CHECKSUM_EN
    send(8'd0);
`endif
    e_last = 0;
    byte_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      byte_data = 8'(i);
      tick();
      drop1();
    end
    byte_valid = 1'b0;
    chk("sat.drop", 64'(drop_count), 64'd255);
    out_ready = 4'h1; tick(); out_ready = '0;
    status("sat");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_dispatch.md
Name: spi_cmd_dispatch

Overview:
Command front-end in the sys_clock domain. Consumes the byte stream from the SPI reader and decodes frames of the form opcode, length, then payload bytes. Each completed frame is delivered to one of NUM_CMDS consumer channels (sprite queue, sprite storage, and others) over a valid/ready handshake. The block also exports the last opcode and error status for LED/debug use, replacing the hard-wired single-command enqueue decode.

Parameters:
NUM_CMDS, 4, number of opcodes/consumer channels; opcode k (0..NUM_CMDS-1) routes to channel k.
PAYLOAD_BYTES, 6, maximum payload bytes per frame; width of out_data is PAYLOAD_BYTES*8.
CNT_W, 8, width of the saturating drop/error counter.

Ports:
sys_clock  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse, chip-select asserted (already synchronised)
frame_end  in  1  one-cycle pulse, chip-select released (already synchronised)
byte_valid  in  1  one-cycle strobe, byte_data is valid
byte_data  in  8  received SPI byte
out_valid  out  NUM_CMDS  one-hot, frame available for channel k
out_ready  in  NUM_CMDS  per-channel accept
out_data  out  PAYLOAD_BYTES*8  payload; byte 0 in [7:0], unused bytes zero
out_len  out  $clog2(PAYLOAD_BYTES+1)  payload byte count
last_cmd  out  8  opcode of the most recent frame
err_unknown  out  1  sticky: opcode >= NUM_CMDS, or length > PAYLOAD_BYTES
err_short  out  1  sticky: frame_end arrived before payload complete
drop_count  out  CNT_W  saturating count of dropped frames/bytes
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; payload register cleared. Sticky errors clear only on rst.
- One clock; sys_clock and rst are the block's clock and reset. Reset is synchronous and active-high.
- IDLE: frame_start -> OPC. A byte_valid seen in IDLE without frame_start is ignored.
- OPC: byte_valid -> latch opcode into last_cmd that same cycle. Opcode valid -> LEN. Opcode invalid -> set err_unknown, increment drop_count, go to DISCARD.
- LEN: byte_valid -> latch L. L > PAYLOAD_BYTES -> set err_unknown, increment drop_count, go to DISCARD. L == 0 -> DISPATCH. Otherwise -> PAYLOAD with the byte counter at 0.
- PAYLOAD: each byte_valid writes byte_data to byte lane [counter] and increments the counter. On byte L-1 -> DISPATCH on the next cycle.
- DISPATCH: out_valid[opcode]=1 and out_data/out_len held stable. When out_ready[opcode] is seen in the same cycle -> IDLE; out_valid drops the following cycle. Dispatch latency is 1 cycle after the last payload byte is registered.
- DISPATCH byte handling: any byte_valid while in DISPATCH (back-pressure) is dropped and increments drop_count. Subsequent frame_start pulses are ignored until the frame is accepted.
- DISCARD: ignore bytes until frame_end -> IDLE.
- frame_end in OPC, LEN, or PAYLOAD: set err_short, increment drop_count, go to IDLE, nothing dispatched. frame_end in IDLE or DISPATCH: no effect.
- Same-cycle frame_end and byte_valid: the byte is processed first, then frame_end is evaluated against the resulting state. Example: the last payload byte together with frame_end results in a normal dispatch.
- frame_start in any state other than IDLE/DISPATCH: restart at OPC, set err_short, increment drop_count.
- drop_count saturates at 2^CNT_W-1.
- rst mid-frame: immediate return to IDLE; the partial payload is discarded and out_valid is deasserted the cycle after rst.

Optional Feature:
CMD_CHECKSUM_EN.
- Defined: after the payload, one extra byte carries the XOR of the opcode, L, and all payload bytes. State CHK precedes DISPATCH. On mismatch: set sticky err_csum (extra 1-bit output port, present only when defined), increment drop_count, go to IDLE without dispatch. The checksum byte is not counted in L.
- Undefined: no CHK state and no err_csum port; frames go straight from PAYLOAD/LEN to DISPATCH.

Decomposition:
- Package cmd_pkg: state enum typedef (IDLE, OPC, LEN, PAYLOAD, CHK, DISPATCH, DISCARD); opcode constants CMD_NOP=0, CMD_ENQUEUE=1, CMD_SPRITE_WR=2, CMD_CLEAR=3; default PAYLOAD_BYTES.
- One natural sub-module, payload_packer: the byte-lane write and counter, with clear, write-strobe, and index inputs, and a packed output.

Test Plan:
- Normal frame: start, 01, 06, 0A 0B 0C 0D 0E 0F, end, out_ready[1]=1 → out_valid=0010 one cycle after the last byte; out_data=0F0E0D0C0B0A; out_len=6; last_cmd=01.
- Back-pressure: same frame with out_ready=0 for 5 cycles and 2 extra bytes sent → out_valid held with data stable; drop_count=2; accepted when ready rises; next frame then dispatches normally.
- Unknown opcode: start, 07, 02, AA BB, end → err_unknown=1; drop_count=1; no out_valid; block returns to IDLE and the next valid frame dispatches.
- Short frame: start, 02, 04, 11 22, end → err_short=1; no dispatch; drop_count increments.
- Zero length: start, 03, 00, end → out_valid[3]; out_len=0; out_data=0.
- Reset mid-payload: rst asserted after 3 of 6 bytes → all outputs 0 the next cycle; a subsequent full frame dispatches correctly. With CMD_CHECKSUM_EN: a bad checksum sets err_csum and blocks dispatch.
